// File: rtl/windowed_feature_engine.sv
// windowed_feature_engine
//   Sliding-window feature extractor for the fall-detection datapath.
//   Each accepted accelerometer sample is reduced to an L1 magnitude
//   |x|+|y|+|z|. Running sum and sum-of-squares are kept over a window
//   of WIN = 2**LOG_WIN samples. Once the window is full, every HOP samples
//   the block emits the window mean, the variance, the peak magnitude since
//   the previous emission, and an impact flag.
//
//   Pipeline: S1 magnitude -> S2 window/sum update + trigger -> S3 emission.
//   A triggering sample presented in cycle n gives feature_valid in cycle n+3.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   clear         synchronous flush of window and pipeline (wins over sample_valid)
//   sample_valid  accel_x/y/z valid this cycle, no backpressure
//   accel_x/y/z   signed DATA_W-bit samples
//   impact_th     unsigned peak threshold, sampled at emission
//   feature_valid one-cycle pulse when feature_* are updated
//   feature_mean  window mean of magnitude
//   feature_var   window variance of magnitude
//   feature_peak  max magnitude since previous emission
//   impact_flag   feature_peak > impact_th
//   window_full   WIN samples held since reset/clear
module windowed_feature_engine #(
   parameter int DATA_W  = 16,
   parameter int LOG_WIN = 5,
   parameter int HOP     = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  sample_valid,
   input  logic [DATA_W-1:0]     accel_x,
   input  logic [DATA_W-1:0]     accel_y,
   input  logic [DATA_W-1:0]     accel_z,
   input  logic [DATA_W+1:0]     impact_th,
   output logic                  feature_valid,
   output logic [DATA_W+1:0]     feature_mean,
   output logic [2*DATA_W+3:0]   feature_var,
   output logic [DATA_W+1:0]     feature_peak,
   output logic                  impact_flag,
   output logic                  window_full
);

   localparam int M   = DATA_W + 2;        // magnitude width
   localparam int WIN = 1 << LOG_WIN;
   localparam int SW  = M + LOG_WIN;       // sum width
   localparam int QW  = 2 * M + LOG_WIN;   // sum-of-squares width
   localparam int CW  = LOG_WIN + 1;       // count / hop counter width

   localparam logic [CW-1:0] WIN_C    = CW'(WIN);
   localparam logic [CW-1:0] WIN_M1   = CW'(WIN - 1);
   localparam logic [CW-1:0] HOP_LAST = CW'(HOP - 1);

   // Unsigned absolute value; the most negative input maps to 2**(DATA_W-1)
   // which still fits in DATA_W unsigned bits.
   function automatic logic [M-1:0] abs_ext(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] a;
      a = v[DATA_W-1] ? (~v + 1'b1) : v;
      return {2'b00, a};
   endfunction

   // ---------------- S1: magnitude ----------------
   logic [M-1:0] mag_r;
   logic         mag_v;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mag_r <= '0;
         mag_v <= 1'b0;
      end else if (clear) begin
         mag_r <= '0;
         mag_v <= 1'b0;
      end else begin
         mag_v <= sample_valid;
         if (sample_valid)
            mag_r <= abs_ext(accel_x) + abs_ext(accel_y) + abs_ext(accel_z);
      end
   end

   // ---------------- S2: window update ----------------
   logic [M-1:0]       ring [WIN];
   logic [LOG_WIN-1:0] wr_ptr;
   logic [CW-1:0]      count;
   logic [CW-1:0]      hop_cnt;
   logic [SW-1:0]      sum;
   logic [QW-1:0]      sumsq;
   logic [M-1:0]       peak;
   logic [M-1:0]       peak_emit;
   logic               trig_r;

   logic          full_now;
   logic [M-1:0]  old;
   logic [M-1:0]  peak_max;
   logic [CW-1:0] count_n;
   logic          trig;

   always_comb begin
      full_now = (count == WIN_C);
      // Until the window is full the slot being overwritten holds no live sample.
      old      = full_now ? ring[wr_ptr] : '0;
      peak_max = (mag_r > peak) ? mag_r : peak;
      count_n  = full_now ? count : count + 1'b1;
      trig     = mag_v && ((count == WIN_M1) || (full_now && (hop_cnt == HOP_LAST)));
   end

   always_ff @(posedge clk) begin
      if (mag_v && !clear)
         ring[wr_ptr] <= mag_r;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         count       <= '0;
         hop_cnt     <= '0;
         sum         <= '0;
         sumsq       <= '0;
         peak        <= '0;
         peak_emit   <= '0;
         trig_r      <= 1'b0;
         window_full <= 1'b0;
      end else if (clear) begin
         wr_ptr      <= '0;
         count       <= '0;
         hop_cnt     <= '0;
         sum         <= '0;
         sumsq       <= '0;
         peak        <= '0;
         peak_emit   <= '0;
         trig_r      <= 1'b0;
         window_full <= 1'b0;
      end else begin
         trig_r <= trig;
         if (mag_v) begin
            wr_ptr      <= wr_ptr + 1'b1;
            count       <= count_n;
            window_full <= (count_n == WIN_C);
            sum         <= sum + SW'(mag_r) - SW'(old);
            sumsq       <= sumsq + (QW'(mag_r) * QW'(mag_r)) - (QW'(old) * QW'(old));
            if (trig)
               hop_cnt <= '0;
            else if (full_now)
               hop_cnt <= hop_cnt + 1'b1;
            // The emitted peak includes the triggering sample; the running
            // peak restarts so the next sample in flight starts a fresh hop.
            if (trig) begin
               peak_emit <= peak_max;
               peak      <= '0;
            end else begin
               peak      <= peak_max;
            end
         end
      end
   end

   // ---------------- S3: emission ----------------
   logic [M-1:0]   mean_c;
   logic [2*M-1:0] ex2_c;
   logic [2*M-1:0] msq_c;
   logic [2*M-1:0] var_c;

   always_comb begin
      mean_c = M'(sum >> LOG_WIN);
      ex2_c  = (2*M)'(sumsq >> LOG_WIN);
      msq_c  = (2*M)'(mean_c) * (2*M)'(mean_c);
      var_c  = (ex2_c >= msq_c) ? (ex2_c - msq_c) : '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         feature_valid <= 1'b0;
         feature_mean  <= '0;
         feature_var   <= '0;
         feature_peak  <= '0;
         impact_flag   <= 1'b0;
      end else if (clear) begin
         feature_valid <= 1'b0;
         feature_mean  <= '0;
         feature_var   <= '0;
         feature_peak  <= '0;
         impact_flag   <= 1'b0;
      end else begin
         feature_valid <= trig_r;
         if (trig_r) begin
            feature_mean <= mean_c;
            feature_var  <= var_c;
            feature_peak <= peak_emit;
            impact_flag  <= (peak_emit > impact_th);
         end
      end
   end

endmodule
